// File: rtl/ins_queue_decoder.sv
// rtl/ins_queue_decoder.sv - instruction FIFO with RV32I decode into a registered dispatch slot
module ins_queue_decoder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_ins,
    input  logic [31:0]       in_pc,
    input  logic              in_pred_taken,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_opcode,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [31:0]       out_imm,
    output logic [31:0]       out_pc,
    output logic              out_pred_taken,
    output logic              out_use_rd,
    output logic              out_use_rs1,
    output logic              out_use_rs2,
    output logic              out_illegal,
    output logic [ADDR_W:0]   count
);
    localparam logic [5:0] OP_LUI = 6'd1, OP_AUIPC = 6'd2, OP_JAL = 6'd3, OP_JALR = 6'd4,
        OP_BEQ = 6'd5, OP_BNE = 6'd6, OP_BLT = 6'd7, OP_BGE = 6'd8, OP_BLTU = 6'd9, OP_BGEU = 6'd10,
        OP_LB = 6'd11, OP_LH = 6'd12, OP_LW = 6'd13, OP_LBU = 6'd14, OP_LHU = 6'd15,
        OP_SB = 6'd16, OP_SH = 6'd17, OP_SW = 6'd18,
        OP_ADDI = 6'd19, OP_SLTI = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22, OP_ORI = 6'd23,
        OP_ANDI = 6'd24, OP_SLLI = 6'd25, OP_SRLI = 6'd26, OP_SRAI = 6'd27,
        OP_ADD = 6'd28, OP_SUB = 6'd29, OP_SLL = 6'd30, OP_SLT = 6'd31, OP_SLTU = 6'd32,
        OP_XOR = 6'd33, OP_SRL = 6'd34, OP_SRA = 6'd35, OP_OR = 6'd36, OP_AND = 6'd37;

    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    logic [31:0]       ins_mem [DEPTH];
    logic [31:0]       pc_mem  [DEPTH];
    logic              pt_mem  [DEPTH];
    logic [ADDR_W-1:0] head, tail;

    assign in_ready = (count != FULL);

    logic enq, load;
    assign enq  = in_valid & in_ready & rdy_in & ~flush_in;
    assign load = rdy_in & ~flush_in & (count != '0) & (~out_valid | out_ready);

    logic [31:0] h;
    logic [2:0]  f3;
    logic [6:0]  f7;
    assign h  = ins_mem[head];
    assign f3 = h[14:12];
    assign f7 = h[31:25];

    logic [5:0]  d_op;
    logic [4:0]  d_rd, d_rs1, d_rs2;
    logic [31:0] d_imm;
    logic        d_urd, d_urs1, d_urs2, legal;

    always_comb begin
        d_op = '0; d_rd = '0; d_rs1 = '0; d_rs2 = '0; d_imm = '0;
        d_urd = 1'b0; d_urs1 = 1'b0; d_urs2 = 1'b0; legal = 1'b0;
        case (h[6:0])
            7'b0110111, 7'b0010111: begin
                legal = 1'b1; d_op = (h[5]) ? OP_LUI : OP_AUIPC;
                d_urd = 1'b1; d_imm = {h[31:12], 12'b0};
            end
            7'b1101111: begin
                legal = 1'b1; d_op = OP_JAL; d_urd = 1'b1;
                d_imm = {{11{h[31]}}, h[31], h[19:12], h[20], h[30:21], 1'b0};
            end
            7'b1100111: begin
                legal = (f3 == 3'b000); d_op = OP_JALR; d_urd = 1'b1; d_urs1 = 1'b1;
                d_imm = {{20{h[31]}}, h[31:20]};
            end
            7'b1100011: begin
                legal = 1'b1; d_urs1 = 1'b1; d_urs2 = 1'b1;
                d_imm = {{19{h[31]}}, h[31], h[7], h[30:25], h[11:8], 1'b0};
                case (f3)
                    3'b000: d_op = OP_BEQ;
                    3'b001: d_op = OP_BNE;
                    3'b100: d_op = OP_BLT;
                    3'b101: d_op = OP_BGE;
                    3'b110: d_op = OP_BLTU;
                    3'b111: d_op = OP_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            7'b0000011: begin
                legal = 1'b1; d_urd = 1'b1; d_urs1 = 1'b1;
                d_imm = {{20{h[31]}}, h[31:20]};
                case (f3)
                    3'b000: d_op = OP_LB;
                    3'b001: d_op = OP_LH;
                    3'b010: d_op = OP_LW;
                    3'b100: d_op = OP_LBU;
                    3'b101: d_op = OP_LHU;
                    default: legal = 1'b0;
                endcase
            end
            7'b0100011: begin
                legal = 1'b1; d_urs1 = 1'b1; d_urs2 = 1'b1;
                d_imm = {{20{h[31]}}, h[31:25], h[11:7]};
                case (f3)
                    3'b000: d_op = OP_SB;
                    3'b001: d_op = OP_SH;
                    3'b010: d_op = OP_SW;
                    default: legal = 1'b0;
                endcase
            end
            7'b0010011: begin
                legal = 1'b1; d_urd = 1'b1; d_urs1 = 1'b1;
                d_imm = {{20{h[31]}}, h[31:20]};
                case (f3)
                    3'b000: d_op = OP_ADDI;
                    3'b010: d_op = OP_SLTI;
                    3'b011: d_op = OP_SLTIU;
                    3'b100: d_op = OP_XORI;
                    3'b110: d_op = OP_ORI;
                    3'b111: d_op = OP_ANDI;
                    3'b001: begin
                        d_op = OP_SLLI; legal = (f7 == 7'b0); d_imm = {27'b0, h[24:20]};
                    end
                    default: begin
                        // ins[30] picks arithmetic shift; every other funct7 bit must be clear
                        d_op = h[30] ? OP_SRAI : OP_SRLI;
                        legal = ({h[31], h[29:25]} == 6'b0); d_imm = {27'b0, h[24:20]};
                    end
                endcase
            end
            7'b0110011: begin
                d_urd = 1'b1; d_urs1 = 1'b1; d_urs2 = 1'b1;
                if (f7 == 7'b0000000) begin
                    legal = 1'b1;
                    case (f3)
                        3'b000: d_op = OP_ADD;
                        3'b001: d_op = OP_SLL;
                        3'b010: d_op = OP_SLT;
                        3'b011: d_op = OP_SLTU;
                        3'b100: d_op = OP_XOR;
                        3'b101: d_op = OP_SRL;
                        3'b110: d_op = OP_OR;
                        default: d_op = OP_AND;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    legal = (f3 == 3'b000) || (f3 == 3'b101);
                    d_op = (f3 == 3'b000) ? OP_SUB : OP_SRA;
                end
            end
            7'b0001111: begin
                legal = 1'b1; d_op = OP_ADDI;
            end
            default: legal = 1'b0;
        endcase
        if (legal) begin
            d_rd  = d_urd  ? h[11:7]  : 5'd0;
            d_rs1 = d_urs1 ? h[19:15] : 5'd0;
            d_rs2 = d_urs2 ? h[24:20] : 5'd0;
        end else begin
            d_op = '0; d_imm = '0; d_urd = 1'b0; d_urs1 = 1'b0; d_urs2 = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (enq && !rst_in) begin
            ins_mem[tail] <= in_ins;
            pc_mem[tail]  <= in_pc;
            pt_mem[tail]  <= in_pred_taken;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head <= '0; tail <= '0; count <= '0;
            out_valid <= 1'b0; out_opcode <= '0; out_rd <= '0; out_rs1 <= '0; out_rs2 <= '0;
            out_imm <= '0; out_pc <= '0; out_pred_taken <= 1'b0; out_use_rd <= 1'b0;
            out_use_rs1 <= 1'b0; out_use_rs2 <= 1'b0; out_illegal <= 1'b0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head <= '0; tail <= '0; count <= '0; out_valid <= 1'b0;
            end else begin
                if (enq) tail <= tail + 1'b1;
                if (load) begin
                    head <= head + 1'b1;
                    out_valid <= 1'b1; out_opcode <= d_op; out_rd <= d_rd;
                    out_rs1 <= d_rs1; out_rs2 <= d_rs2; out_imm <= d_imm;
                    out_pc <= pc_mem[head]; out_pred_taken <= pt_mem[head];
                    out_use_rd <= d_urd; out_use_rs1 <= d_urs1; out_use_rs2 <= d_urs2;
                    out_illegal <= ~legal;
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                if (enq && !load) count <= count + 1'b1;
                else if (load && !enq) count <= count - 1'b1;
            end
        end
    end
endmodule

// File: doc/ins_queue_decoder.md
Name: ins_queue_decoder

Overview:
Parametrised decode stage between instruction fetch and dispatch. It buffers fetched instructions in a DEPTH-entry FIFO, with each instruction's PC and predicted-taken bit. The FIFO head is decoded with the full RV32I decode and the result is held in a registered output slot, handed to dispatch by valid/ready handshake. Compared with the bare combinational decoder, it adds queueing, back-pressure, flush, operand-use flags and illegal-instruction detection.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2.
ADDR_W, $clog2(DEPTH), FIFO pointer width (derived).

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, synchronous, active-high
rdy_in  input  1  global enable; 0 freezes all state
flush_in  input  1  mispredict flush; discards all buffered instructions
in_valid  input  1  fetch presents an instruction
in_ready  output  1  queue can accept an instruction
in_ins  input  32  raw instruction word
in_pc  input  32  instruction PC
in_pred_taken  input  1  branch-predictor taken bit
out_valid  output  1  decoded instruction available
out_ready  input  1  dispatch accepts the output
out_opcode  output  6  internal opcode (shared OP_* macro encoding)
out_rd  output  5  destination register; 0 if unused
out_rs1  output  5  source register 1; 0 if unused
out_rs2  output  5  source register 2; 0 if unused
out_imm  output  32  sign-/zero-extended immediate; 0 if none
out_pc  output  32  PC of the decoded instruction
out_pred_taken  output  1  forwarded predictor bit
out_use_rd, out_use_rs1, out_use_rs2  output  1 each  operand-use flags
out_illegal  output  1  instruction is not a supported RV32I encoding
count  output  ADDR_W+1  FIFO occupancy (excludes output slot)

Behaviour:
- Reset (rst_in=1 at a clock edge): head/tail pointers and count go to 0. All out_* outputs go to 0, including out_valid. in_ready=1. Reset takes priority over flush_in and rdy_in.
- rdy_in=0: no state changes and no handshake completes. Outputs hold their values.
- Enqueue fires when in_valid & in_ready & rdy_in & !flush_in. The instruction is written at the tail and the tail wraps modulo DEPTH.
- in_ready = (count != DEPTH). It is derived from registered count only. When the FIFO is full, a same-cycle dequeue does not admit a new entry.
- The output slot loads when the FIFO is non-empty and (!out_valid | out_ready). It takes the decode of the head entry; the head advances and out_valid is set. If the FIFO is empty and out_ready & out_valid, out_valid clears.
- Latency: an instruction enqueued into an empty FIFO with an empty slot shows out_valid two edges later. Throughput is 1 per cycle when sustained.
- count is +1 on enqueue only, -1 on slot load only, and unchanged when both occur.
- flush_in=1 (with rdy_in=1): at the next edge, pointers and count go to 0 and out_valid goes to 0. Same-cycle input and output handshakes are discarded.
- Decode (combinational on head; all fields default to 0, no latches):
  - LUI / AUIPC: rd; imm = {ins[31:12], 12'b0}.
  - JAL: rd; imm = sext{ins[31], ins[19:12], ins[20], ins[30:21], 0}.
  - JALR: funct3 must be 000; rd, rs1; imm = sext ins[31:20].
  - Branch: funct3 in {000,001,100,101,110,111}; rs1, rs2; imm = sext{ins[31], ins[7], ins[30:25], ins[11:8], 0}.
  - Load: funct3 in {000,001,010,100,101}; rd, rs1; I-immediate.
  - Store: funct3 in {000,001,010}; rs1, rs2; imm = sext{ins[31:25], ins[11:7]}.
  - OP-IMM: select on funct3. SLLI requires funct7=0000000. SRLI/SRAI are selected by ins[30] and the other funct7 bits must be 0. Shift imm = zero-extended shamt.
  - OP: funct7 must be 0000000, or 0100000 for SUB/SRA only.
  - FENCE (0001111): treated as NOP, i.e. OP_ADDI with rd=rs1=0 and imm=0. use_rd=0, use_rs1=0.
  - Anything else, including ECALL/EBREAK/CSR: out_illegal=1, opcode=0, use flags 0. The entry still flows through the handshake normally.
- use_rd is 1 only when rd is architecturally written. rd=x0 still reports use_rd=1; the consumer handles x0.
- out_pc and out_pred_taken travel with the entry unchanged.

Test Plan:
- Reset, then idle -> out_valid=0, in_ready=1, count=0, all out_* 0.
- Enqueue 0x00500093 at pc 0x100, out_ready=1 -> out_valid two edges later; opcode OP_ADDI, rd=1, rs1=0, imm=5, use_rs2=0, pc=0x100, illegal=0.
- Enqueue 0xFE000EE3 (beq x0,x0,-4) -> opcode OP_BEQ, imm=0xFFFFFFFC, use_rd=0, use_rs1=use_rs2=1.
- out_ready=0, in_valid held high, DEPTH=16 -> exactly 17 accepted (16 in FIFO plus 1 in slot); in_ready=0 and count=16. One output handshake -> count=15 and in_ready=1 on the following cycle. Outputs emerge in order.
- 5 entries queued, then flush_in=1 with in_valid=1 -> next cycle count=0, out_valid=0; the flushed-cycle input never appears.
- Enqueue 0x00000073 -> out_illegal=1. Enqueue 0x0000B023 (store, funct3=011) -> out_illegal=1. Enqueue 0x0000000F -> OP_ADDI NOP, illegal=0. rdy_in=0 for 3 cycles mid-stream -> state frozen, no entries lost or duplicated.
